// File: rtl/d_cache_pkg.sv
// ----------------------------------------------------------------------------
// d_cache_pkg
// Shared widths, counts and types for the data-cache refill path.
//   TAG_W / LINE_W / WORD_W : split of the 32-bit word address {tag,line,word}
//   NUM_LINES / WORDS_PER_LINE : direct-mapped geometry (4 lines x 4 words)
//   refill_state_e : refill controller states
//   miss_addr_t    : captured address of the missing access
// Optional feature (selected in d_cache_refill_ctrl): DCACHE_CRIT_WORD_FIRST_EN
// ----------------------------------------------------------------------------
package d_cache_pkg;

    localparam int TAG_W          = 28;
    localparam int LINE_W         = 2;
    localparam int WORD_W         = 2;
    localparam int NUM_LINES      = 4;
    localparam int WORDS_PER_LINE = 4;
    localparam int DATA_W         = 32;
    localparam int ADDR_W         = TAG_W + LINE_W + WORD_W;
    localparam int BEAT_W         = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        UPDATE = 2'd2
    } refill_state_e;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [LINE_W-1:0] line;
        logic [WORD_W-1:0] word;
    } miss_addr_t;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

endpackage

// File: rtl/d_cache_tag_store.sv
// ----------------------------------------------------------------------------
// d_cache_tag_store
// Tag and valid register arrays, one generate slice per cache line.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   tag_we, tag_line, tag_wdata : write tag_wdata into tag_array_o[tag_line]
//   set_valid                : set valid_array_o[tag_line]
//   clr_line_en, clr_line    : clear valid_array_o[clr_line]
//   clr_all                  : clear every valid bit (tags untouched)
//   tag_array_o, valid_array_o : storage, read by the lookup stage
// Clear has priority over set on the same line; clear-all over everything.
// ----------------------------------------------------------------------------
module d_cache_tag_store
    import d_cache_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              tag_we,
    input  logic [LINE_W-1:0]                 tag_line,
    input  logic [TAG_W-1:0]                  tag_wdata,
    input  logic                              set_valid,
    input  logic                              clr_line_en,
    input  logic [LINE_W-1:0]                 clr_line,
    input  logic                              clr_all,
    output logic [NUM_LINES-1:0][TAG_W-1:0]   tag_array_o,
    output logic [NUM_LINES-1:0]              valid_array_o
);

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
        logic sel_wr;
        logic sel_clr;

        assign sel_wr  = (tag_line == LINE_W'(g));
        assign sel_clr = clr_line_en && (clr_line == LINE_W'(g));

        always_ff @(posedge clk) begin
            if (rst) begin
                tag_array_o[g] <= '0;
            end else if (tag_we && sel_wr) begin
                tag_array_o[g] <= tag_wdata;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_array_o[g] <= 1'b0;
            end else if (clr_all || sel_clr) begin
                valid_array_o[g] <= 1'b0;
            end else if (set_valid && sel_wr) begin
                valid_array_o[g] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/d_cache_refill_ctrl.sv
// ----------------------------------------------------------------------------
// d_cache_refill_ctrl
// Refills one 4-word line on a lookup miss, writes it into the data array,
// forwards the requested word to the core and commits tag/valid at the end.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   miss_i, tagid_i/lineid_i/wordid_i : miss request and its address
//   flush_i                          : invalidate all lines (IDLE only)
//   mem_req_o, mem_addr_o            : memory read request / word address
//   mem_ack_i, mem_rdata_i           : beat accepted / beat data
//   tag_array_o, valid_array_o       : tag store contents
//   line_we_o, line_wr_*_o           : data-array write port (one cycle after ack)
//   crit_valid_o, crit_data_o        : requested word, alongside its write
//   busy_o, refill_done_o            : refill in progress / completion pulse
// Build option: DCACHE_CRIT_WORD_FIRST_EN fetches the requested word first
// and wraps; otherwise words are fetched 0,1,2,3.
// ----------------------------------------------------------------------------
module d_cache_refill_ctrl
    import d_cache_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              miss_i,
    input  logic [TAG_W-1:0]                  tagid_i,
    input  logic [LINE_W-1:0]                 lineid_i,
    input  logic [WORD_W-1:0]                 wordid_i,
    input  logic                              flush_i,
    output logic                              mem_req_o,
    output logic [ADDR_W-1:0]                 mem_addr_o,
    input  logic                              mem_ack_i,
    input  logic [DATA_W-1:0]                 mem_rdata_i,
    output logic [NUM_LINES-1:0][TAG_W-1:0]   tag_array_o,
    output logic [NUM_LINES-1:0]              valid_array_o,
    output logic                              line_we_o,
    output logic [LINE_W-1:0]                 line_wr_line_o,
    output logic [WORD_W-1:0]                 line_wr_word_o,
    output logic [DATA_W-1:0]                 line_wr_data_o,
    output logic                              crit_valid_o,
    output logic [DATA_W-1:0]                 crit_data_o,
    output logic                              busy_o,
    output logic                              refill_done_o
);

    refill_state_e     state_q, state_d;

    miss_addr_t        miss_q;
    logic [WORD_W-1:0] word_ptr_q;
    logic [BEAT_W-1:0] beat_q;
    logic              wr_vld_q;
    logic [WORD_W-1:0] wr_word_q;
    logic [DATA_W-1:0] wr_data_q;

    logic              capture;
    logic              beat_ack;
    logic              tag_commit;
    logic              flush_all;
    logic [WORD_W-1:0] start_word;

`ifdef DCACHE_CRIT_WORD_FIRST_EN
    assign start_word = wordid_i;
`else
    assign start_word = '0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        busy_o        = 1'b0;
        mem_req_o     = 1'b0;
        refill_done_o = 1'b0;
        capture       = 1'b0;
        beat_ack      = 1'b0;
        tag_commit    = 1'b0;
        flush_all     = 1'b0;
        case (state_q)
            IDLE: begin
                // flush has priority; a coincident miss is dropped
                if (flush_i) begin
                    flush_all = 1'b1;
                end else if (miss_i) begin
                    capture = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                busy_o    = 1'b1;
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    beat_ack = 1'b1;
                    if (beat_q == LAST_BEAT) state_d = UPDATE;
                end
            end
            UPDATE: begin
                busy_o        = 1'b1;
                refill_done_o = 1'b1;
                tag_commit    = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_q     <= '0;
            word_ptr_q <= '0;
            beat_q     <= '0;
            wr_vld_q   <= 1'b0;
            wr_word_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            if (capture) begin
                miss_q     <= '{tag: tagid_i, line: lineid_i, word: wordid_i};
                word_ptr_q <= start_word;
                beat_q     <= '0;
            end
            // beat data is registered and written to the data array next cycle
            wr_vld_q <= beat_ack;
            if (beat_ack) begin
                wr_word_q  <= word_ptr_q;
                wr_data_q  <= mem_rdata_i;
                word_ptr_q <= word_ptr_q + 1'b1;
                beat_q     <= beat_q + 1'b1;
            end
        end
    end

    assign mem_addr_o     = {miss_q.tag, miss_q.line, word_ptr_q};
    assign line_we_o      = wr_vld_q;
    assign line_wr_line_o = miss_q.line;
    assign line_wr_word_o = wr_word_q;
    assign line_wr_data_o = wr_data_q;
    assign crit_valid_o   = wr_vld_q && (wr_word_q == miss_q.word);
    assign crit_data_o    = crit_valid_o ? wr_data_q : '0;

    // ---------------- tag / valid store ----------------
    // valid[line] drops on the capture edge so the lookup cannot hit a
    // half-refilled line; it is set again together with the tag in UPDATE.
    d_cache_tag_store u_tag_store (
        .clk           (clk),
        .rst           (rst),
        .tag_we        (tag_commit),
        .tag_line      (miss_q.line),
        .tag_wdata     (miss_q.tag),
        .set_valid     (tag_commit),
        .clr_line_en   (capture),
        .clr_line      (lineid_i),
        .clr_all       (flush_all),
        .tag_array_o   (tag_array_o),
        .valid_array_o (valid_array_o)
    );

endmodule

// File: tb/tb_d_cache_refill_ctrl.sv
// ----------------------------------------------------------------------------
// tb_d_cache_refill_ctrl
// Directed bench for d_cache_refill_ctrl. Expected word order follows
// DCACHE_CRIT_WORD_FIRST_EN when the bench is built with it.
// ----------------------------------------------------------------------------
module tb_d_cache_refill_ctrl;

`ifdef DCACHE_CRIT_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              miss_i;
    logic [27:0]       tagid_i;
    logic [1:0]        lineid_i;
    logic [1:0]        wordid_i;
    logic              flush_i;
    logic              mem_req_o;
    logic [31:0]       mem_addr_o;
    logic              mem_ack_i;
    logic [31:0]       mem_rdata_i;
    logic [3:0][27:0]  tag_array_o;
    logic [3:0]        valid_array_o;
    logic              line_we_o;
    logic [1:0]        line_wr_line_o;
    logic [1:0]        line_wr_word_o;
    logic [31:0]       line_wr_data_o;
    logic              crit_valid_o;
    logic [31:0]       crit_data_o;
    logic              busy_o;
    logic              refill_done_o;

    d_cache_refill_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .miss_i         (miss_i),
        .tagid_i        (tagid_i),
        .lineid_i       (lineid_i),
        .wordid_i       (wordid_i),
        .flush_i        (flush_i),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_ack_i      (mem_ack_i),
        .mem_rdata_i    (mem_rdata_i),
        .tag_array_o    (tag_array_o),
        .valid_array_o  (valid_array_o),
        .line_we_o      (line_we_o),
        .line_wr_line_o (line_wr_line_o),
        .line_wr_word_o (line_wr_word_o),
        .line_wr_data_o (line_wr_data_o),
        .crit_valid_o   (crit_valid_o),
        .crit_data_o    (crit_data_o),
        .busy_o         (busy_o),
        .refill_done_o  (refill_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference copy of the tag/valid store
    logic [27:0] exp_tag [4];
    logic [3:0]  exp_valid;

    // per-refill monitor state
    logic [27:0] cur_tag;
    logic [1:0]  cur_line;
    logic [1:0]  cur_word;
    int          nw;
    int          n_done;
    int          step_n;
    int          done_step;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] bdata(input logic [27:0] t, input int b);
        return {8'hA5, t[15:0], 8'(b)};
    endfunction

    function automatic logic [1:0] word_of(input logic [1:0] w, input int b);
        logic [1:0] bb;
        bb = 2'(b);
        return CWF ? (w + bb) : bb;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // step and record any data-array write / completion pulse
    task automatic mstep();
        logic [1:0] we;
        step();
        step_n++;
        if (line_we_o) begin
            we = word_of(cur_word, nw);
            chk("wr_line", line_wr_line_o, cur_line);
            chk("wr_word", line_wr_word_o, we);
            chk("wr_data", line_wr_data_o, bdata(cur_tag, nw));
            chk("crit_valid", crit_valid_o, (we == cur_word));
            if (we == cur_word) chk("crit_data", crit_data_o, bdata(cur_tag, nw));
            nw++;
        end else begin
            chk("crit_idle", crit_valid_o, 1'b0);
        end
        if (refill_done_o) begin
            n_done++;
            done_step = step_n;
        end
    endtask

    task automatic chk_store(input string name);
        chk({name, "_valid"}, valid_array_o, exp_valid);
        for (int i = 0; i < 4; i++) chk({name, "_tag"}, tag_array_o[i], exp_tag[i]);
    endtask

    task automatic refill(input logic [27:0] t, input logic [1:0] l, input logic [1:0] w,
                          input int gap, input bit stray);
        logic [1:0] wexp;
        int         cnt;
        cur_tag = t; cur_line = l; cur_word = w;
        nw = 0; n_done = 0; step_n = 0; done_step = 0;
        tagid_i = t; lineid_i = l; wordid_i = w; miss_i = 1'b1; mem_ack_i = 1'b0;
        mstep();
        miss_i = 1'b0;
        exp_valid[l] = 1'b0;
        chk("busy_fetch", busy_o, 1'b1);
        chk_store("miss_clear");
        for (int b = 0; b < 4; b++) begin
            wexp = word_of(w, b);
            for (int g = 0; g <= gap; g++) begin
                chk("mem_req", mem_req_o, 1'b1);
                chk("mem_addr", mem_addr_o, {t, l, wexp});
                mem_ack_i   = (g == gap);
                mem_rdata_i = (g == gap) ? bdata(t, b) : 32'hDEAD_BEEF;
                if (stray && b == 1 && g == gap) begin
                    miss_i = 1'b1; tagid_i = ~t; lineid_i = l + 2'd1;
                end
                mstep();
                miss_i = 1'b0; tagid_i = t; lineid_i = l;
            end
        end
        mem_ack_i = 1'b0;
        chk("mem_req_update", mem_req_o, 1'b0);
        cnt = 0;
        while (busy_o && cnt < 8) begin
            mstep();
            cnt++;
        end
        chk("busy_end", busy_o, 1'b0);
        mstep();
        mstep();
        exp_valid[l] = 1'b1;
        exp_tag[l]   = t;
        chk("writes", nw, 4);
        chk("done_pulses", n_done, 1);
        chk("done_cycle", done_step + 1, 6 + 4 * gap);
        chk_store("refill");
    endtask

    initial begin
        rst = 1'b1; miss_i = 1'b0; tagid_i = '0; lineid_i = '0; wordid_i = '0;
        flush_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = '0;
        exp_valid = '0;
        for (int i = 0; i < 4; i++) exp_tag[i] = '0;
        cur_tag = '0; cur_line = '0; cur_word = '0;
        nw = 0; n_done = 0; step_n = 0; done_step = 0;

        // reset state
        step(); step();
        rst = 1'b0;
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk("rst_we", line_we_o, 1'b0);
        chk("rst_done", refill_done_o, 1'b0);
        chk("rst_crit", crit_valid_o, 1'b0);
        chk_store("rst");

        // immediate acks, requested word 1
        refill(28'h000ABC, 2'd2, 2'd1, 0, 1'b0);
        // three idle cycles before each ack
        refill(28'h1234567, 2'd1, 2'd3, 3, 1'b0);

        // stray acks in IDLE are ignored
        mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_2222;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stray_ack_busy", busy_o, 1'b0);
            chk("stray_ack_req", mem_req_o, 1'b0);
            chk("stray_ack_we", line_we_o, 1'b0);
        end
        mem_ack_i = 1'b0;
        chk_store("stray_ack");

        // miss pulsed during FETCH (targets valid line 1) is ignored
        refill(28'hFFFFFFF, 2'd0, 2'd0, 0, 1'b1);
        // fill the last line so all four are valid
        refill(28'h0000055, 2'd3, 2'd2, 0, 1'b0);
        chk("all_valid", valid_array_o, 4'hF);

        // flush together with miss: flush wins
        flush_i = 1'b1; miss_i = 1'b1; tagid_i = 28'h0000999; lineid_i = 2'd0;
        step();
        flush_i = 1'b0; miss_i = 1'b0;
        exp_valid = '0;
        chk_store("flush");
        chk("flush_req", mem_req_o, 1'b0);
        chk("flush_busy", busy_o, 1'b0);
        step();
        chk("flush_req2", mem_req_o, 1'b0);
        chk("flush_busy2", busy_o, 1'b0);

        refill(28'h0000777, 2'd0, 2'd2, 0, 1'b0);

        // reset after the 2nd ack abandons the refill
        tagid_i = 28'h000ABC; lineid_i = 2'd2; wordid_i = 2'd1; miss_i = 1'b1;
        mem_ack_i = 1'b1; mem_rdata_i = 32'h5555_0000;
        step();
        miss_i = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) exp_tag[i] = '0;
        exp_valid = '0;
        chk("rrst_busy", busy_o, 1'b0);
        chk("rrst_req", mem_req_o, 1'b0);
        chk("rrst_we", line_we_o, 1'b0);
        chk("rrst_done", refill_done_o, 1'b0);
        chk_store("rrst");
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_we", line_we_o, 1'b0);
            chk("post_rst_done", refill_done_o, 1'b0);
            chk("post_rst_busy", busy_o, 1'b0);
        end
        mem_ack_i = 1'b0;
        chk_store("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
